// File: rtl/axi_ad9364_chk_pkg.sv
// Shared definitions for the AD9364 loopback pattern checker and the tx
// pattern generator: state encoding, default (I,Q) pattern words, widths
// and the received sample payload.
package axi_ad9364_chk_pkg;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned ERR_CNT_W   = 16;
  localparam int unsigned SMP_CNT_W   = 32;
  localparam int unsigned MATCH_CNT_W = 8;
  localparam int unsigned IDLE_CNT_W  = 16;
  localparam int unsigned STATE_W     = 2;

  // Default alternating pattern driven by the tx generator
  localparam logic [DATA_W-1:0] PAT_I_A_DEF = 12'o2064;
  localparam logic [DATA_W-1:0] PAT_Q_A_DEF = 12'o1753;
  localparam logic [DATA_W-1:0] PAT_I_B_DEF = 12'o4402;
  localparam logic [DATA_W-1:0] PAT_Q_B_DEF = 12'o1337;
  localparam logic [DATA_W-1:0] CHK_MASK_DEF = 12'hfff;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // One received sample set, both channels
  typedef struct packed {
    logic [DATA_W-1:0] i1;
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] i2;
    logic [DATA_W-1:0] q2;
  } adc_smp_t;

endpackage

// File: rtl/axi_ad9364_chk_cmp.sv
// Masked compare of one sample set against both pattern phases.
//   r1_mode   : 1 = only channel 1 is compared
//   smp       : received I1/Q1/I2/Q2 words
//   match_a_c : sample equals phase-A pattern (combinational)
//   match_b_c : sample equals phase-B pattern (combinational)
module axi_ad9364_chk_cmp
  import axi_ad9364_chk_pkg::*;
#(
  parameter logic [DATA_W-1:0] PAT_I_A  = PAT_I_A_DEF,
  parameter logic [DATA_W-1:0] PAT_Q_A  = PAT_Q_A_DEF,
  parameter logic [DATA_W-1:0] PAT_I_B  = PAT_I_B_DEF,
  parameter logic [DATA_W-1:0] PAT_Q_B  = PAT_Q_B_DEF,
  parameter logic [DATA_W-1:0] CHK_MASK = CHK_MASK_DEF
) (
  input  logic     r1_mode,
  input  adc_smp_t smp,
  output logic     match_a_c,
  output logic     match_b_c
);

  localparam logic [DATA_W-1:0] EXP_I_A = PAT_I_A & CHK_MASK;
  localparam logic [DATA_W-1:0] EXP_Q_A = PAT_Q_A & CHK_MASK;
  localparam logic [DATA_W-1:0] EXP_I_B = PAT_I_B & CHK_MASK;
  localparam logic [DATA_W-1:0] EXP_Q_B = PAT_Q_B & CHK_MASK;

  logic ch1_a, ch1_b, ch2_a, ch2_b;

  // Per-channel compare, then fold channel 2 in unless in r1 mode
  always_comb begin
    ch1_a = ((smp.i1 & CHK_MASK) == EXP_I_A) && ((smp.q1 & CHK_MASK) == EXP_Q_A);
    ch1_b = ((smp.i1 & CHK_MASK) == EXP_I_B) && ((smp.q1 & CHK_MASK) == EXP_Q_B);
    ch2_a = ((smp.i2 & CHK_MASK) == EXP_I_A) && ((smp.q2 & CHK_MASK) == EXP_Q_A);
    ch2_b = ((smp.i2 & CHK_MASK) == EXP_I_B) && ((smp.q2 & CHK_MASK) == EXP_Q_B);
    match_a_c = ch1_a && (r1_mode || ch2_a);
    match_b_c = ch1_b && (r1_mode || ch2_b);
  end

endmodule

// File: rtl/axi_ad9364_rx_pattern_chk.sv
// Receive-side checker for the alternating A/B loopback pattern of the
// AD9364 interface. Locks after LOCK_CNT consecutive in-phase samples,
// drops to SEARCH after UNLOCK_CNT consecutive misses, and counts errors
// and checked samples while locked.
//   clk, rstn          : interface clock, async active-low reset
//   chk_enable         : level, 0 forces IDLE
//   chk_clear          : pulse, clears error/sample counters (and timeout)
//   adc_r1_mode        : 1 = channel 1 only
//   adc_valid, adc_data_* : received sample set
//   chk_locked, chk_err, chk_err_cnt, chk_sample_cnt, chk_state, chk_timeout
// Optional: define AD9364_CHK_TIMEOUT_EN to add the no-valid timeout;
// otherwise chk_timeout is tied 0.
module axi_ad9364_rx_pattern_chk
  import axi_ad9364_chk_pkg::*;
#(
  parameter logic [DATA_W-1:0] PAT_I_A     = PAT_I_A_DEF,
  parameter logic [DATA_W-1:0] PAT_Q_A     = PAT_Q_A_DEF,
  parameter logic [DATA_W-1:0] PAT_I_B     = PAT_I_B_DEF,
  parameter logic [DATA_W-1:0] PAT_Q_B     = PAT_Q_B_DEF,
  parameter logic [DATA_W-1:0] CHK_MASK    = CHK_MASK_DEF,
  parameter int unsigned       LOCK_CNT    = 8,
  parameter int unsigned       UNLOCK_CNT  = 4,
  parameter int unsigned       TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 chk_enable,
  input  logic                 chk_clear,
  input  logic                 adc_r1_mode,
  input  logic                 adc_valid,
  input  logic [DATA_W-1:0]    adc_data_i1,
  input  logic [DATA_W-1:0]    adc_data_q1,
  input  logic [DATA_W-1:0]    adc_data_i2,
  input  logic [DATA_W-1:0]    adc_data_q2,
  output logic                 chk_locked,
  output logic                 chk_err,
  output logic [ERR_CNT_W-1:0] chk_err_cnt,
  output logic [SMP_CNT_W-1:0] chk_sample_cnt,
  output logic [STATE_W-1:0]   chk_state,
  output logic                 chk_timeout
);

  localparam logic [MATCH_CNT_W-1:0] LOCK_LIM   = MATCH_CNT_W'(LOCK_CNT);
  localparam logic [MATCH_CNT_W-1:0] UNLOCK_LIM = MATCH_CNT_W'(UNLOCK_CNT);

  // Elaboration-time parameter range checks
  if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock_cnt
    $error("LOCK_CNT must be in 1..255");
  end
  if (UNLOCK_CNT < 1 || UNLOCK_CNT > 255) begin : g_bad_unlock_cnt
    $error("UNLOCK_CNT must be in 1..255");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout_cyc
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  adc_smp_t smp;
  logic     match_a, match_b, exp_match;

  chk_state_e                 state_q, state_d;
  logic                       phase_q, phase_d;  // 0: expect A, 1: expect B
  logic [MATCH_CNT_W-1:0]     match_cnt_q, match_cnt_d;
  logic [MATCH_CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic [ERR_CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic [SMP_CNT_W-1:0]       smp_cnt_q, smp_cnt_d;
  logic                       err_q, err_d;
  logic                       locked_q;

`ifdef AD9364_CHK_TIMEOUT_EN
  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LIM = IDLE_CNT_W'(TIMEOUT_CYC);
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                  timeout_q, timeout_d;
`endif

  assign smp = '{i1: adc_data_i1, q1: adc_data_q1, i2: adc_data_i2, q2: adc_data_q2};

  axi_ad9364_chk_cmp #(
    .PAT_I_A  (PAT_I_A),
    .PAT_Q_A  (PAT_Q_A),
    .PAT_I_B  (PAT_I_B),
    .PAT_Q_B  (PAT_Q_B),
    .CHK_MASK (CHK_MASK)
  ) u_cmp (
    .r1_mode   (adc_r1_mode),
    .smp       (smp),
    .match_a_c (match_a),
    .match_b_c (match_b)
  );

  assign exp_match = phase_q ? match_b : match_a;

  // Next-state and counter update
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_cnt_d   = err_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    err_d       = 1'b0;
`ifdef AD9364_CHK_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
    timeout_d   = timeout_q;
`endif

    if (!chk_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;

        ST_SEARCH: begin
          if (adc_valid) begin
            if (exp_match) begin
              // Saturate so a stale count held across IDLE cannot wrap
              if (match_cnt_q != '1) match_cnt_d = match_cnt_q + MATCH_CNT_W'(1);
              phase_d = ~phase_q;
            end else if (match_a || match_b) begin
              // Out of phase: resync on this sample
              phase_d     = match_a;
              match_cnt_d = MATCH_CNT_W'(1);
            end else begin
              match_cnt_d = '0;
            end
            if (match_cnt_d >= LOCK_LIM) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (adc_valid) begin
            phase_d   = ~phase_q;
            smp_cnt_d = smp_cnt_q + SMP_CNT_W'(1);
            if (exp_match) begin
              miss_cnt_d = '0;
            end else begin
              err_d = 1'b1;
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
              miss_cnt_d = miss_cnt_q + MATCH_CNT_W'(1);
              if (miss_cnt_d == UNLOCK_LIM) begin
                state_d     = ST_SEARCH;
                match_cnt_d = '0;
              end
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

`ifdef AD9364_CHK_TIMEOUT_EN
    // Idle watchdog: only runs while actively searching or locked
    if (chk_enable && (state_q == ST_SEARCH || state_q == ST_LOCKED)) begin
      if (adc_valid) begin
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
        if (idle_cnt_d == TIMEOUT_LIM) begin
          timeout_d   = 1'b1;
          state_d     = ST_SEARCH;
          match_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
    end else begin
      idle_cnt_d = '0;
    end
    if (state_q == ST_IDLE || chk_clear) timeout_d = 1'b0;
`endif

    // Clear has priority over a same-cycle increment
    if (chk_clear) begin
      err_cnt_d = '0;
      smp_cnt_d = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q     <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_cnt_q   <= err_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      err_q       <= err_d;
      locked_q    <= (state_d == ST_LOCKED);
    end
  end

`ifdef AD9364_CHK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign chk_timeout = timeout_q;
`else
  assign chk_timeout = 1'b0;
`endif

  assign chk_locked     = locked_q;
  assign chk_err        = err_q;
  assign chk_err_cnt    = err_cnt_q;
  assign chk_sample_cnt = smp_cnt_q;
  assign chk_state      = state_q;

endmodule

// File: tb/tb_axi_ad9364_rx_pattern_chk.sv
// Directed bench for axi_ad9364_rx_pattern_chk: a vector table for lock,
// errors, unlock, resync, r1 mode and clear; hand sequences for timeout,
// async reset and error-counter saturation (second instance, UNLOCK_CNT=255).
module tb_axi_ad9364_rx_pattern_chk;

  localparam logic [11:0] AI = 12'o2064;
  localparam logic [11:0] AQ = 12'o1753;
  localparam logic [11:0] BI = 12'o4402;
  localparam logic [11:0] BQ = 12'o1337;

  // Sample codes
  localparam int C_A   = 0;  // A on both channels
  localparam int C_B   = 1;  // B on both channels
  localparam int C_BAD = 2;  // I1 = 0, rest A
  localparam int C_A1  = 3;  // A on ch1, ch2 zero
  localparam int C_B1  = 4;  // B on ch1, ch2 zero

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        en, clr, r1, vld;
  logic [11:0] i1, q1, i2, q2;
  logic        locked, err, tmo;
  logic [15:0] ecnt;
  logic [31:0] scnt;
  logic [1:0]  st;

  logic        en2, clr2, vld2;
  logic [11:0] i1b, q1b, i2b, q2b;
  logic        locked2, err2, tmo2;
  logic [15:0] ecnt2;
  logic [31:0] scnt2;
  logic [1:0]  st2;

  axi_ad9364_rx_pattern_chk #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .chk_enable(en), .chk_clear(clr),
    .adc_r1_mode(r1), .adc_valid(vld),
    .adc_data_i1(i1), .adc_data_q1(q1), .adc_data_i2(i2), .adc_data_q2(q2),
    .chk_locked(locked), .chk_err(err), .chk_err_cnt(ecnt),
    .chk_sample_cnt(scnt), .chk_state(st), .chk_timeout(tmo)
  );

  axi_ad9364_rx_pattern_chk #(.UNLOCK_CNT(255), .TIMEOUT_CYC(16)) dut2 (
    .clk(clk), .rstn(rstn), .chk_enable(en2), .chk_clear(clr2),
    .adc_r1_mode(1'b0), .adc_valid(vld2),
    .adc_data_i1(i1b), .adc_data_q1(q1b), .adc_data_i2(i2b), .adc_data_q2(q2b),
    .chk_locked(locked2), .chk_err(err2), .chk_err_cnt(ecnt2),
    .chk_sample_cnt(scnt2), .chk_state(st2), .chk_timeout(tmo2)
  );

  typedef struct {
    logic        en, clr, r1, vld;
    int          code;
    logic        e_lock;
    logic [1:0]  e_state;
    logic        e_err;
    logic [15:0] e_ecnt;
    logic [31:0] e_scnt;
  } vec_t;

  vec_t tbl[$];
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic e, input logic c, input logic r, input logic v, input int code,
                     input logic el, input logic [1:0] es, input logic ee,
                     input logic [15:0] ec, input logic [31:0] esc);
    vec_t t;
    t.en = e; t.clr = c; t.r1 = r; t.vld = v; t.code = code;
    t.e_lock = el; t.e_state = es; t.e_err = ee; t.e_ecnt = ec; t.e_scnt = esc;
    tbl.push_back(t);
  endtask

  function automatic logic [47:0] words(input int code);
    case (code)
      C_A:     return {AI, AQ, AI, AQ};
      C_B:     return {BI, BQ, BI, BQ};
      C_BAD:   return {12'o0000, AQ, AI, AQ};
      C_A1:    return {AI, AQ, 24'h0};
      C_B1:    return {BI, BQ, 24'h0};
      default: return 48'h0;
    endcase
  endfunction

  task automatic step2(input logic v, input logic c, input int code);
    vld2 = v; clr2 = c;
    {i1b, q1b, i2b, q2b} = words(code);
    @(posedge clk); #1;
  endtask

  initial begin
    int   errs, miss, smp;
    logic ph;

    en = 0; clr = 0; r1 = 0; vld = 0; {i1, q1, i2, q2} = words(C_A);
    en2 = 0; clr2 = 0; vld2 = 0; {i1b, q1b, i2b, q2b} = words(C_A);

    // Lock on 8 alternating samples
    add(1,0,0,0,C_A,   0,2'd1,0,16'd0,32'd0);
    for (int k = 0; k < 7; k++) add(1,0,0,1,(k%2==0)?C_A:C_B, 0,2'd1,0,16'd0,32'd0);
    add(1,0,0,1,C_B,   1,2'd2,0,16'd0,32'd0);
    // Single error, then recovery
    add(1,0,0,1,C_A,   1,2'd2,0,16'd0,32'd1);
    add(1,0,0,1,C_BAD, 1,2'd2,1,16'd1,32'd2);
    add(1,0,0,1,C_A,   1,2'd2,0,16'd1,32'd3);
    add(1,0,0,1,C_B,   1,2'd2,0,16'd1,32'd4);
    // Three misses then a good one: miss count restarts
    add(1,0,0,1,C_BAD, 1,2'd2,1,16'd2,32'd5);
    add(1,0,0,1,C_BAD, 1,2'd2,1,16'd3,32'd6);
    add(1,0,0,1,C_BAD, 1,2'd2,1,16'd4,32'd7);
    add(1,0,0,1,C_B,   1,2'd2,0,16'd4,32'd8);
    // Four misses: lose lock
    add(1,0,0,1,C_BAD, 1,2'd2,1,16'd5,32'd9);
    add(1,0,0,1,C_BAD, 1,2'd2,1,16'd6,32'd10);
    add(1,0,0,1,C_BAD, 1,2'd2,1,16'd7,32'd11);
    add(1,0,0,1,C_BAD, 0,2'd1,1,16'd8,32'd12);
    add(1,0,0,0,C_A,   0,2'd1,0,16'd8,32'd12);
    // Relock
    for (int k = 0; k < 7; k++) add(1,0,0,1,(k%2==0)?C_A:C_B, 0,2'd1,0,16'd8,32'd12);
    add(1,0,0,1,C_B,   1,2'd2,0,16'd8,32'd12);
    // Disable, re-enable, start out of phase: B,A,A,B,A,B,A,B,A,B
    add(0,0,0,0,C_A,   0,2'd0,0,16'd8,32'd12);
    add(1,0,0,0,C_A,   0,2'd1,0,16'd8,32'd12);
    add(1,0,0,1,C_B,   0,2'd1,0,16'd8,32'd12);
    add(1,0,0,1,C_A,   0,2'd1,0,16'd8,32'd12);
    for (int k = 0; k < 7; k++) add(1,0,0,1,(k%2==0)?C_A:C_B, 0,2'd1,0,16'd8,32'd12);
    add(1,0,0,1,C_B,   1,2'd2,0,16'd8,32'd12);
    // r1 mode ignores ch2; two-channel mode does not
    add(1,0,1,1,C_A1,  1,2'd2,0,16'd8,32'd13);
    add(1,0,0,1,C_B1,  1,2'd2,1,16'd9,32'd14);
    add(1,0,0,1,C_A,   1,2'd2,0,16'd9,32'd15);
    // Clear on an error cycle wins
    add(1,1,0,1,C_BAD, 1,2'd2,1,16'd0,32'd0);
    add(1,0,0,1,C_A,   1,2'd2,0,16'd0,32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst locked", locked, 0);
    chk("rst state", st, 0);
    chk("rst err", err, 0);
    chk("rst err_cnt", ecnt, 0);
    chk("rst sample_cnt", scnt, 0);
    chk("rst timeout", tmo, 0);
    rstn = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; clr = tbl[i].clr; r1 = tbl[i].r1; vld = tbl[i].vld;
      {i1, q1, i2, q2} = words(tbl[i].code);
      @(posedge clk); #1;
      chk($sformatf("v%0d locked", i), locked, tbl[i].e_lock);
      chk($sformatf("v%0d state", i), st, tbl[i].e_state);
      chk($sformatf("v%0d err", i), err, tbl[i].e_err);
      chk($sformatf("v%0d err_cnt", i), ecnt, tbl[i].e_ecnt);
      chk($sformatf("v%0d sample_cnt", i), scnt, tbl[i].e_scnt);
    end
    clr = 0; vld = 0;

    // Timeout: 15 idle cycles no effect, 16th trips (when compiled in)
    repeat (15) @(posedge clk);
    #1;
    chk("idle15 state", st, 2);
    chk("idle15 timeout", tmo, 0);
    @(posedge clk); #1;
`ifdef AD9364_CHK_TIMEOUT_EN
    chk("idle16 timeout", tmo, 1);
    chk("idle16 state", st, 1);
    chk("idle16 locked", locked, 0);
`else
    chk("idle16 timeout", tmo, 0);
    chk("idle16 state", st, 2);
    chk("idle16 locked", locked, 1);
`endif
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    chk("clear timeout", tmo, 0);
    chk("clear sample_cnt", scnt, 0);

    // Async reset takes effect without a clock edge
    #2 rstn = 0;
    #1;
    chk("async rst state", st, 0);
    chk("async rst locked", locked, 0);
    @(posedge clk); #1;
    rstn = 1; en = 0;

    // Saturation on dut2
    en2 = 1;
    step2(0, 0, C_A);
    for (int k = 0; k < 8; k++) step2(1, 0, (k%2==0) ? C_A : C_B);
    chk("sat lock", locked2, 1);
    errs = 0; miss = 0; smp = 0; ph = 0;
    while (errs < 65535) begin
      if (miss == 254) begin
        step2(1, 0, ph ? C_B : C_A);
        miss = 0;
      end else begin
        step2(1, 0, C_BAD);
        miss++; errs++;
      end
      ph = ~ph; smp++;
    end
    chk("sat err_cnt ffff", ecnt2, 16'hffff);
    chk("sat sample_cnt", scnt2, smp);
    chk("sat still locked", locked2, 1);
    if (miss >= 253) begin
      step2(1, 0, ph ? C_B : C_A);
      ph = ~ph; smp++;
    end
    step2(1, 0, C_BAD);
    chk("sat hold err", err2, 1);
    chk("sat hold err_cnt", ecnt2, 16'hffff);
    chk("sat hold sample_cnt", scnt2, smp + 1);
    step2(1, 1, C_BAD);
    chk("sat clear err", err2, 1);
    chk("sat clear err_cnt", ecnt2, 0);
    chk("sat clear sample_cnt", scnt2, 0);
    chk("sat clear locked", locked2, 1);
    vld2 = 0; clr2 = 0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
